load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter n, default 32: data and address width.
REQ-002 Parameter TMO, default 16: maximum bus wait cycles before a timeout fault.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 Req  input  1  memory operation request from the execute stage.
REQ-006 We  input  1  1 = store, 0 = load.
REQ-007 Memsel  input  3  load type: 000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU; 101-111 illegal.
REQ-008 Sdsel  input  2  store size: 00 word, 01 half, 10 byte; 11 illegal.
REQ-009 Addr  input  n  byte address.
REQ-010 DataW  input  n  store data, right-aligned.
REQ-011 Stall  output  1  pipeline hold.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 Fault  output  1  misaligned/illegal/timeout flag, valid with Done.
REQ-014 DataR  output  n  load data shifted to bit 0, for the load-extract stage.
REQ-015 MemValid  output  1  bus request valid.
REQ-016 MemReady  input  1  bus acceptance/response.
REQ-017 MemWe  output  1  bus write.
REQ-018 MemAddr  output  n  word-aligned address: {Addr[n-1:2], 2'b00}.
REQ-019 MemBe  output  4  byte enables.
REQ-020 MemWdata  output  n  lane-replicated store data.
REQ-021 MemRdata  input  n  bus read data, valid when MemValid and MemReady are both high.

Function
REQ-022 The FSM SHALL have states IDLE, BUS, DONE.
REQ-023 In IDLE with Req=1, the unit SHALL latch We, Memsel, Sdsel, Addr and DataW on the clock edge.
REQ-024 From IDLE, an aligned and legal request SHALL go to BUS; any other request SHALL go directly to DONE with the fault flag set and no bus activity.
REQ-025 Size SHALL be: word for LW and Sdsel 00; half for LH, LHU and Sdsel 01; byte for LB, LBU and Sdsel 10.
REQ-026 Misaligned SHALL mean: word with Addr[1:0] not 00, or half with Addr[0]=1.
REQ-027 Illegal Memsel (loads) or illegal Sdsel (stores) SHALL be a fault.
REQ-028 In BUS, MemValid SHALL be 1, and MemAddr, MemWe, MemBe and MemWdata SHALL be held stable until MemReady=1 is sampled.
REQ-029 MemBe SHALL be 1111 for word, 0011<<off for half, and 0001<<off for byte, where off=Addr[1:0].
REQ-030 MemWdata SHALL be DataW for word, {2{DataW[15:0]}} for half, and {4{DataW[7:0]}} for byte.
REQ-031 On a BUS cycle with MemReady=1, the unit SHALL go to DONE; for a load, DataR SHALL be registered as MemRdata >> (8*off).
REQ-032 In BUS, a wait counter SHALL increment each cycle with MemReady=0; on reaching TMO-1, the unit SHALL go to DONE with the fault flag set, drop MemValid, and leave DataR unchanged.
REQ-033 In DONE, Done SHALL be 1 for exactly one cycle; Fault SHALL be valid in that cycle; the next state SHALL be IDLE.
REQ-034 Stall SHALL be combinational: 1 when (state==IDLE and Req=1) or state==BUS; 0 in DONE.
REQ-035 Req SHALL be ignored outside IDLE.
REQ-036 A back-to-back request SHALL be accepted in the IDLE cycle that follows DONE.
REQ-037 DataR SHALL hold its value until the next successful load capture; stores and faults SHALL NOT modify it.
REQ-038 Fault SHALL be 0 whenever Done=0.
REQ-039 Latency for an aligned access with MemReady already high SHALL be: request edge, one BUS cycle, Done on the third cycle.

Reset
REQ-040 rst=1 SHALL immediately force state IDLE, MemValid 0, MemWe 0, MemBe 0000, MemAddr 0, MemWdata 0, Done 0, Fault 0, DataR 0, wait counter 0.
REQ-041 Assertion of rst mid-BUS SHALL abort the transaction with no Done pulse.
REQ-042 After rst deasserts, the first edge with Req=1 SHALL be accepted normally.

Verification
REQ-043 Load LB at Addr=0x1003, MemRdata=0x80FF_1234, MemReady=1 -> MemBe=1000, DataR=0x0000_0080, Done pulse, Fault=0.
REQ-044 Store Sdsel=01 at Addr=0x2002, DataW=0xDEAD_BEEF -> MemBe=1100, MemWdata=0xBEEF_BEEF, MemWe=1, MemAddr=0x2000.
REQ-045 LW at Addr=0x3001 -> MemValid stays 0, Done=1 with Fault=1, DataR unchanged.
REQ-046 MemReady held 0 -> MemValid=1 for exactly TMO cycles (16), then Done=1 with Fault=1, MemValid=0.
REQ-047 MemReady delayed 3 cycles, rst pulsed during the second wait cycle -> MemValid=0 immediately, no Done, state IDLE.
REQ-048 Two loads issued back-to-back with Req held high -> two Done pulses with Stall=0 only in each DONE cycle, and both DataR values correct.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: decodes size and alignment, runs one bus transaction per
// request with a timeout, and returns load data shifted down to bit 0.
module load_store_unit #(
  parameter int n   = 32,
  parameter int TMO = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Req,
  input  logic         We,
  input  logic [2:0]   Memsel,
  input  logic [1:0]   Sdsel,
  input  logic [n-1:0] Addr,
  input  logic [n-1:0] DataW,
  output logic         Stall,
  output logic         Done,
  output logic         Fault,
  output logic [n-1:0] DataR,
  output logic         MemValid,
  input  logic         MemReady,
  output logic         MemWe,
  output logic [n-1:0] MemAddr,
  output logic [3:0]   MemBe,
  output logic [n-1:0] MemWdata,
  input  logic [n-1:0] MemRdata
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

  state_t        state_q, state_d;
  size_t         size_c;
  logic          illegal_c, misalign_c, bad_c;
  logic [3:0]    be_c;
  logic [n-1:0]  wdata_c;
  logic          we_q;
  logic [1:0]    off_q;
  logic          fault_q;
  logic [CW-1:0] wait_cnt;
  logic          bus_timeout;

  // Size and legality come from Memsel for loads and Sdsel for stores.
  always_comb begin
    size_c    = SZ_WORD;
    illegal_c = 1'b0;
    if (We) begin
      case (Sdsel)
        2'b00:   size_c = SZ_WORD;
        2'b01:   size_c = SZ_HALF;
        2'b10:   size_c = SZ_BYTE;
        default: illegal_c = 1'b1;
      endcase
    end else begin
      case (Memsel)
        3'b000:  size_c = SZ_WORD;
        3'b001:  size_c = SZ_HALF;
        3'b010:  size_c = SZ_BYTE;
        3'b011:  size_c = SZ_HALF;
        3'b100:  size_c = SZ_BYTE;
        default: illegal_c = 1'b1;
      endcase
    end
    misalign_c = ((size_c == SZ_WORD) && (Addr[1:0] != 2'b00)) ||
                 ((size_c == SZ_HALF) && Addr[0]);
    bad_c      = illegal_c | misalign_c;
  end

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = DataW;
    case (size_c)
      SZ_WORD: begin
        be_c    = 4'b1111;
        wdata_c = DataW;
      end
      SZ_HALF: begin
        be_c    = 4'b0011 << Addr[1:0];
        wdata_c = {(n/16){DataW[15:0]}};
      end
      SZ_BYTE: begin
        be_c    = 4'b0001 << Addr[1:0];
        wdata_c = {(n/8){DataW[7:0]}};
      end
      default: be_c = 4'b0000;
    endcase
  end

  assign bus_timeout = !MemReady && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Req) state_d = bad_c ? DONE : BUS;
      BUS:     if (MemReady || bus_timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request fields are captured at acceptance so the bus side stays stable
  // no matter what the execute stage drives afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      off_q    <= 2'b00;
      fault_q  <= 1'b0;
      wait_cnt <= '0;
      MemAddr  <= '0;
      MemBe    <= 4'b0000;
      MemWdata <= '0;
      DataR    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req) begin
            we_q     <= We;
            off_q    <= Addr[1:0];
            fault_q  <= bad_c;
            wait_cnt <= '0;
            MemAddr  <= {Addr[n-1:2], 2'b00};
            MemBe    <= be_c;
            MemWdata <= wdata_c;
          end
        end
        BUS: begin
          if (MemReady) begin
            if (!we_q) DataR <= MemRdata >> {off_q, 3'b000};
          end else if (bus_timeout) begin
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign MemValid = (state_q == BUS);
  assign MemWe    = (state_q == BUS) && we_q;
  assign Done     = (state_q == DONE);
  assign Fault    = (state_q == DONE) && fault_q;
  assign Stall    = ((state_q == IDLE) && Req) || (state_q == BUS);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed bus lanes, load data,
// fault and timeout behaviour, reset abort and back-to-back requests.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        Req;
  logic        We;
  logic [2:0]  Memsel;
  logic [1:0]  Sdsel;
  logic [31:0] Addr;
  logic [31:0] DataW;
  logic        Stall;
  logic        Done;
  logic        Fault;
  logic [31:0] DataR;
  logic        MemValid;
  logic        MemReady;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBe;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;

  int checkCount = 0;
  int errorCount = 0;

  load_store_unit #(.n(32), .TMO(16)) dut (
    .clk(clk), .rst(rst), .Req(Req), .We(We), .Memsel(Memsel), .Sdsel(Sdsel),
    .Addr(Addr), .DataW(DataW), .Stall(Stall), .Done(Done), .Fault(Fault),
    .DataR(DataR), .MemValid(MemValid), .MemReady(MemReady), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemBe(MemBe), .MemWdata(MemWdata), .MemRdata(MemRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [2:0] memsel,
                               input logic [1:0] sdsel, input logic [31:0] addr,
                               input logic [31:0] dataw);
    Req    = req;
    We     = we;
    Memsel = memsel;
    Sdsel  = sdsel;
    Addr   = addr;
    DataW  = dataw;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Request rejected at decode: straight to DONE with a fault, no bus cycle.
  task automatic faultOnly(input string tag, input logic we, input logic [2:0] memsel,
                           input logic [1:0] sdsel, input logic [31:0] addr,
                           input logic [31:0] keepData);
    applyStimulus(1'b1, we, memsel, sdsel, addr, 32'h0);
    checkOutput({tag, "_stall"}, 32'(Stall), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checkOutput({tag, "_valid"}, 32'(MemValid), 32'd0);
    checkOutput({tag, "_done"}, 32'(Done), 32'd1);
    checkOutput({tag, "_fault"}, 32'(Fault), 32'd1);
    checkOutput({tag, "_datar"}, DataR, keepData);
    tick();
    checkOutput({tag, "_idle"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int validCycles;
    int donePulses;

    rst = 1'b0; Req = 1'b0; We = 1'b0; Memsel = 3'b000; Sdsel = 2'b00;
    Addr = 32'h0; DataW = 32'h0; MemReady = 1'b0; MemRdata = 32'h0;
    #2 rst = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(MemValid), 32'd0);
    checkOutput("rst_we",    32'(MemWe),    32'd0);
    checkOutput("rst_be",    32'(MemBe),    32'd0);
    checkOutput("rst_addr",  MemAddr,       32'd0);
    checkOutput("rst_wdata", MemWdata,      32'd0);
    checkOutput("rst_done",  32'(Done),     32'd0);
    checkOutput("rst_fault", 32'(Fault),    32'd0);
    checkOutput("rst_datar", DataR,         32'd0);
    checkOutput("rst_stall", 32'(Stall),    32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] LB at 0x1003");
    MemReady = 1'b1; MemRdata = 32'h80FF_1234;
    applyStimulus(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_1003, 32'h0);
    checkOutput("lb_stall_idle", 32'(Stall), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checkOutput("lb_valid", 32'(MemValid), 32'd1);
    checkOutput("lb_be",    32'(MemBe),    32'b1000);
    checkOutput("lb_addr",  MemAddr,       32'h0000_1000);
    checkOutput("lb_we",    32'(MemWe),    32'd0);
    checkOutput("lb_stall_bus", 32'(Stall), 32'd1);
    checkOutput("lb_nodone", 32'(Done),    32'd0);
    tick();
    checkOutput("lb_done",  32'(Done),     32'd1);
    checkOutput("lb_fault", 32'(Fault),    32'd0);
    checkOutput("lb_datar", DataR,         32'h0000_0080);
    checkOutput("lb_stall_done", 32'(Stall), 32'd0);
    checkOutput("lb_valid_done", 32'(MemValid), 32'd0);
    tick();
    checkOutput("lb_idle", 32'(Done), 32'd0);

    $display("[TB] SH at 0x2002");
    applyStimulus(1'b1, 1'b1, 3'b000, 2'b01, 32'h0000_2002, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checkOutput("sh_valid", 32'(MemValid), 32'd1);
    checkOutput("sh_be",    32'(MemBe),    32'b1100);
    checkOutput("sh_wdata", MemWdata,      32'hBEEF_BEEF);
    checkOutput("sh_we",    32'(MemWe),    32'd1);
    checkOutput("sh_addr",  MemAddr,       32'h0000_2000);
    tick();
    checkOutput("sh_done",  32'(Done),     32'd1);
    checkOutput("sh_fault", 32'(Fault),    32'd0);
    checkOutput("sh_datar", DataR,         32'h0000_0080);
    tick();

    $display("[TB] SB at 0x2101");
    applyStimulus(1'b1, 1'b1, 3'b000, 2'b10, 32'h0000_2101, 32'h1234_56A5);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checkOutput("sb_be",    32'(MemBe),    32'b0010);
    checkOutput("sb_wdata", MemWdata,      32'hA5A5_A5A5);
    tick();
    checkOutput("sb_done",  32'(Done),     32'd1);
    tick();

    $display("[TB] decode faults");
    faultOnly("lw_mis",  1'b0, 3'b000, 2'b00, 32'h0000_3001, 32'h0000_0080);
    faultOnly("lh_mis",  1'b0, 3'b001, 2'b00, 32'h0000_3003, 32'h0000_0080);
    faultOnly("ld_ill",  1'b0, 3'b101, 2'b00, 32'h0000_3000, 32'h0000_0080);
    faultOnly("st_ill",  1'b1, 3'b000, 2'b11, 32'h0000_3000, 32'h0000_0080);
    faultOnly("sw_mis",  1'b1, 3'b000, 2'b00, 32'h0000_3002, 32'h0000_0080);

    $display("[TB] LBU at 0x4001");
    MemRdata = 32'h1234_5678;
    applyStimulus(1'b1, 1'b0, 3'b100, 2'b00, 32'h0000_4001, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checkOutput("lbu_be", 32'(MemBe), 32'b0010);
    tick();
    checkOutput("lbu_done",  32'(Done),  32'd1);
    checkOutput("lbu_fault", 32'(Fault), 32'd0);
    checkOutput("lbu_datar", DataR,      32'h0012_3456);
    tick();

    $display("[TB] timeout");
    MemReady = 1'b0; MemRdata = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_5000, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    validCycles = 0;
    for (int i = 0; i < 40 && MemValid; i++) begin
      validCycles++;
      tick();
    end
    checkOutput("tmo_cycles", 32'(validCycles), 32'd16);
    checkOutput("tmo_done",   32'(Done),        32'd1);
    checkOutput("tmo_fault",  32'(Fault),       32'd1);
    checkOutput("tmo_valid",  32'(MemValid),    32'd0);
    checkOutput("tmo_datar",  DataR,            32'h0012_3456);
    tick();

    $display("[TB] reset during bus wait");
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_6000, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checkOutput("abort_valid_pre", 32'(MemValid), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(MemValid), 32'd0);
    checkOutput("abort_stall", 32'(Stall),    32'd0);
    checkOutput("abort_datar", DataR,         32'd0);
    tick();
    rst = 1'b0;
    MemReady = 1'b1;
    donePulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (Done) donePulses++;
      tick();
    end
    checkOutput("abort_nodone", 32'(donePulses), 32'd0);

    $display("[TB] back-to-back loads");
    MemRdata = 32'h1122_3344;
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_7000, 32'h0);
    checkOutput("b2b_stall0", 32'(Stall), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b011, 2'b00, 32'h0000_7002, 32'h0);
    checkOutput("b2b_stall1", 32'(Stall), 32'd1);
    checkOutput("b2b_addr1",  MemAddr,    32'h0000_7000);
    tick();
    checkOutput("b2b_done1",  32'(Done),  32'd1);
    checkOutput("b2b_stall2", 32'(Stall), 32'd0);
    checkOutput("b2b_fault1", 32'(Fault), 32'd0);
    checkOutput("b2b_data1",  DataR,      32'h1122_3344);
    MemRdata = 32'hAABB_CCDD;
    tick();
    checkOutput("b2b_stall3", 32'(Stall), 32'd1);
    checkOutput("b2b_nodone", 32'(Done),  32'd0);
    tick();
    checkOutput("b2b_stall4", 32'(Stall), 32'd1);
    checkOutput("b2b_be2",    32'(MemBe), 32'b1100);
    checkOutput("b2b_addr2",  MemAddr,    32'h0000_7000);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checkOutput("b2b_done2",  32'(Done),  32'd1);
    checkOutput("b2b_stall5", 32'(Stall), 32'd0);
    checkOutput("b2b_data2",  DataR,      32'h0000_AABB);
    tick();
    checkOutput("b2b_idle",   32'(Stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
